quant_scheduler: RTL and testbench
==================================

// Module: quant_scheduler
// PURPOSE
//   Shares one combinational Quantizer (ACC_WIDTH -> DATA_WIDTH) between N_REQ accumulator
//   requesters, e.g. PE-array columns draining results.
//   Arbitrates round-robin and drives the shared quantizer input.
//   Registers the quantized result with the winner's ID onto a valid/ready output stream.
//   Counts one tile of TILE_LEN results, then pulses done.
// PARAMETERS
//   N_REQ     4             number of accumulator requesters (>=2)
//   ACC_W     `ACC_WIDTH    accumulator / quantizer input width (signed)
//   DATA_W    `DATA_WIDTH   quantized result width (signed)
//   TILE_LEN  16            results per tile (>=1)
//   ID_W      $clog2(N_REQ) requester ID width (derived)
//   CNT_W     $clog2(TILE_LEN+1) result-counter width (derived)
// PORTS
//   clk           in   1            clock, rising edge
//   rst_n         in   1            asynchronous reset, active-low
//   start         in   1            begin a tile; honoured only in IDLE
//   req_valid     in   N_REQ        per-requester data valid
//   req_ready     out  N_REQ        per-requester accept (one-hot or zero)
//   req_data      in   N_REQ*ACC_W  packed signed accumulators; requester i at [i*ACC_W +: ACC_W]
//   q_in          out  ACC_W        to shared Quantizer .in
//   q_out         in   DATA_W       from shared Quantizer .out (combinational)
//   out_valid     out  1            result valid
//   out_ready     in   1            downstream accept
//   out_data      out  DATA_W       registered quantized result
//   out_id        out  ID_W         requester index of out_data
//   busy          out  1            high in RUN and DRAIN
//   done          out  1            one-cycle pulse at tile completion
//   result_count  out  CNT_W        requests accepted in the current tile
// BEHAVIOUR
//   Reset (async assert, sync deassert):
//   - state=IDLE, rr_ptr=0, result_count=0.
//   - out_valid, out_data, out_id, done and busy = 0; req_ready=0; q_in=0.
//   FSM:
//   - IDLE:  start -> RUN; result_count cleared to 0 on the same edge.
//   - RUN:   arbitrate (below); the acceptance making result_count==TILE_LEN -> DRAIN.
//   - DRAIN: no grants; when out_valid==0 or (out_valid&&out_ready) -> DONE.
//   - DONE:  done=1 for exactly this cycle -> IDLE; result_count holds its final value.
//   - start outside IDLE is ignored.
//   Arbitration (RUN only):
//   - can_load = !out_valid || out_ready.
//   - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   - Granted only if can_load; then req_ready[g]=1 combinationally, all others 0.
//   - q_in = req_data[g] when a grant is given, else 0.
//   - On grant edge: out_data<=q_out, out_id<=g, out_valid<=1,
//     result_count+=1, rr_ptr<=(g+1) mod N_REQ.
//   - No grant and out_ready && out_valid: out_valid<=0.
//   - req_ready never depends on out_valid of a cycle-later value (no comb loop through q_out).
//   Timing:
//   - Latency 1 cycle, request accept -> out_valid.
//   - Throughput 1 result/cycle while out_ready=1.
//   Output stability:
//   - While out_valid && !out_ready: out_data and out_id hold, no grants, rr_ptr holds.
//   Boundaries:
//   - No req_valid in RUN: idle cycles, state remains RUN indefinitely.
//   - Single active requester: granted every cycle regardless of rr_ptr.
//   - Never accepts more than TILE_LEN requests per tile.
//   - Reset mid-tile: discards the pending output and the count.
// TESTING
//   1. Reset: rst_n=0 mid-RUN with out_valid=1 -> outputs 0 and req_ready=0 immediately (async);
//      after release, state IDLE.
//   2. Fairness: N_REQ=4, all req_valid=1, out_ready=1, TILE_LEN=8, start
//      -> out_id sequence 0,1,2,3,0,1,2,3, then done pulse, busy=0.
//   3. Backpressure: out_ready=0 for 5 cycles after first result -> out_data/out_id frozen,
//      req_ready=0 throughout, no result lost or duplicated.
//   4. Sparse: only req 2 valid with data 'sd1000 -> q_in='sd1000 on grant;
//      out_data equals golden Quantizer('sd1000) one cycle later, out_id=2, every cycle.
//   5. Tile end: TILE_LEN=3, out_ready held 0 after 3rd accept -> DRAIN, no 4th grant;
//      release out_ready -> done exactly 1 cycle after handshake.
//   6. start asserted during RUN and DRAIN -> ignored, count unaffected.

Source files
------------

// File: rtl/quant_scheduler.sv
// Round-robin sharing of one combinational quantizer between N_REQ accumulator
// requesters, with a registered valid/ready result stream and per-tile counting.
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module quant_scheduler #(
    parameter int N_REQ    = 4,
    parameter int ACC_W    = `ACC_WIDTH,
    parameter int DATA_W   = `DATA_WIDTH,
    parameter int TILE_LEN = 16,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(TILE_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ACC_W-1:0] req_data,
    output logic [ACC_W-1:0]       q_in,
    input  logic [DATA_W-1:0]      q_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       result_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] nxt_ptr;
    logic            found;
    logic            can_load;
    logic            grant;
    logic [CNT_W-1:0] cnt_inc;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin : arb
        logic [ID_W-1:0] idx;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign can_load  = !out_valid || out_ready;
    assign grant     = (state == RUN) && can_load && found;
    assign req_ready = grant ? (N_REQ'(1) << gnt) : '0;
    assign q_in      = grant ? req_data[int'(gnt)*ACC_W +: ACC_W] : '0;
    assign nxt_ptr   = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
    assign cnt_inc   = result_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            result_count <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        result_count <= '0;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (grant) begin
                        out_data     <= q_out;
                        out_id       <= gnt;
                        out_valid    <= 1'b1;
                        result_count <= cnt_inc;
                        rr_ptr       <= nxt_ptr;
                        if (cnt_inc == CNT_W'(TILE_LEN))
                            state <= DRAIN;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                // Last result must leave the output register before done.
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_scheduler.sv
// Randomized bench for quant_scheduler against a behavioural model, with
// directed fairness, backpressure, sparse, drain and reset scenarios.
module tb_quant_scheduler;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TL = 8;
    localparam int IW = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            out_ready = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_data = '0;
    logic [AW-1:0]   q_in;
    logic [DW-1:0]   q_out;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            busy;
    logic            done;
    logic [CW-1:0]   result_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Golden quantizer: arithmetic shift by 4, saturate to signed 8 bits.
    function automatic logic [DW-1:0] quant(input logic [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = $signed(a) >>> 4;
        if (s > 127) return 8'h7f;
        if (s < -128) return 8'h80;
        return s[DW-1:0];
    endfunction

    assign q_out = quant(q_in);

    quant_scheduler #(
        .N_REQ(N), .ACC_W(AW), .DATA_W(DW), .TILE_LEN(TL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .q_in(q_in), .q_out(q_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id),
        .busy(busy), .done(done), .result_count(result_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state (phase: 0 idle, 1 run, 2 drain, 3 done)
    int          m_phase, m_ptr, m_cnt, m_oid;
    logic        m_ov;
    logic [DW-1:0] m_od;

    typedef struct {
        int          id;
        logic [DW-1:0] d;
    } item_t;
    item_t sb[$];
    int    hs_ids[$];

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_cnt = 0; m_oid = 0;
        m_ov = 1'b0; m_od = '0;
        sb.delete();
    endtask

    initial begin
        int            g, idx;
        logic          can;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] exp_q;
        item_t         it;
        int            n_phase, n_ptr, n_cnt, n_oid;
        logic          n_ov;
        logic [DW-1:0] n_od;
        model_reset();
        forever begin
            @(negedge clk);
            n_phase = m_phase; n_ptr = m_ptr; n_cnt = m_cnt;
            n_oid = m_oid; n_ov = m_ov; n_od = m_od;
            if (!rst_n) begin
                model_reset();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_q_in", q_in, 0);
                chk("rst_busy", busy, 0);
            end else begin
                can = !m_ov || out_ready;
                g = -1;
                if (m_phase == 1 && can)
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
                exp_rdy = (g >= 0) ? N'(1) << g : '0;
                exp_q   = (g >= 0) ? req_data[g*AW +: AW] : '0;
                chk("req_ready", req_ready, exp_rdy);
                chk("q_in", q_in, exp_q);
                chk("out_valid", out_valid, m_ov);
                chk("out_data", out_data, m_od);
                chk("out_id", out_id, m_oid);
                chk("busy", busy, (m_phase == 1 || m_phase == 2));
                chk("done", done, (m_phase == 3));
                chk("result_count", result_count, m_cnt);
                // Every accepted request must come out exactly once, in order.
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_extra_output", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        chk("sb_id", out_id, it.id);
                        chk("sb_data", out_data, it.d);
                    end
                    hs_ids.push_back(int'(out_id));
                end
                for (int i = 0; i < N; i++)
                    if (req_valid[i] && req_ready[i])
                        sb.push_back('{i, quant(req_data[i*AW +: AW])});
                case (m_phase)
                    0: if (start) begin n_phase = 1; n_cnt = 0; end
                    1: begin
                        if (g >= 0) begin
                            n_ov = 1'b1; n_od = quant(exp_q); n_oid = g;
                            n_cnt = m_cnt + 1; n_ptr = (g + 1) % N;
                            if (n_cnt == TL) n_phase = 2;
                        end else if (out_ready && m_ov) begin
                            n_ov = 1'b0;
                        end
                    end
                    2: if (!m_ov || out_ready) begin n_ov = 1'b0; n_phase = 3; end
                    default: n_phase = 0;
                endcase
            end
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_phase = n_phase; m_ptr = n_ptr; m_cnt = n_cnt;
                m_oid = n_oid; m_ov = n_ov; m_od = n_od;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_acc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return AW'(int'($urandom_range(0, 8000)) - 4000);
    endfunction

    task automatic rnd_data();
        for (int i = 0; i < N; i++) req_data[i*AW +: AW] = rnd_acc();
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            rnd_data();
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || done) && n < lim) begin
            rnd_data();
            tick();
            n++;
        end
        chk("idle_timeout", busy || done, 0);
    endtask

    initial begin
        int            n;
        int            exp_seq[8];
        logic [DW-1:0] d0;
        logic [IW-1:0] id0;
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("init_out_data", out_data, 0);
        chk("init_out_id", out_id, 0);
        chk("init_done", done, 0);
        chk("init_count", result_count, 0);
        rst_n = 1'b1;
        tick();

        // Fairness: everyone requesting, no backpressure.
        req_valid = '1; out_ready = 1'b1; rnd_data();
        start = 1'b1; tick(); start = 1'b0;
        hs_ids.delete();
        wait_done("fair_done_timeout", 40);
        chk("fair_count", result_count, 8);
        chk("fair_len", hs_ids.size(), 8);
        for (int i = 0; i < 8 && i < hs_ids.size(); i++)
            chk("fair_id_seq", hs_ids[i], exp_seq[i]);
        tick();
        chk("fair_done_pulse", done, 0);
        chk("fair_busy_after", busy, 0);

        // Backpressure for 5 cycles, start during RUN ignored.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin rnd_data(); tick(); n++; end
        chk("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        d0 = out_data; id0 = out_id;
        for (int i = 0; i < 5; i++) begin
            rnd_data(); start = 1'b1; tick();
            chk("bp_hold_data", out_data, d0);
            chk("bp_hold_id", out_id, id0);
            chk("bp_no_grant", req_ready, 0);
            chk("bp_count", result_count, 1);
        end
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            rnd_data(); out_ready = ($urandom_range(0, 1) == 1); tick(); n++;
        end
        chk("bp_done_timeout", done, 1);
        out_ready = 1'b1;
        wait_idle(20);

        // Sparse: only requester 2, data 1000.
        req_valid = 4'b0100;
        rnd_data();
        req_data[2*AW +: AW] = 32'sd1000;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("sparse_q_in", q_in, 32'sd1000);
            chk("sparse_data", out_data, 8'd62);
            chk("sparse_id", out_id, 2);
            tick();
        end
        req_valid = '1;
        wait_done("sparse_done_timeout", 40);
        wait_idle(20);

        // Tile end: hold the last result in DRAIN, start ignored.
        req_valid = '1; out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (result_count != CW'(TL) && n < 40) begin rnd_data(); tick(); n++; end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; rnd_data(); tick();
            chk("drain_busy", busy, 1);
            chk("drain_no_done", done, 0);
            chk("drain_no_grant", req_ready, 0);
            chk("drain_count", result_count, 8);
            chk("drain_valid", out_valid, 1);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain_done_next", done, 1);
        tick();
        chk("drain_done_once", done, 0);
        chk("drain_count_hold", result_count, 8);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rnd_data();
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            tick();
        end
        start = 1'b0; req_valid = '1; out_ready = 1'b1;
        wait_idle(60);

        // Asynchronous reset mid-RUN with a pending result.
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_id", out_id, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_q_in", q_in, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", result_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_no_grant", req_ready, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
